// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    localparam int unsigned DATA_W = 32;

    // Access size encoding as driven by the CPU; 2'b11 is illegal.
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: byte enables, write merge and read extraction.
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] old_word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] merged_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] shifted;

    // Decode the size/offset into lanes and pick the read lane from the old word.
    always_comb begin
        be_o    = 4'b0000;
        shifted = '0;
        rdata_o = '0;
        case (size_i)
            SZ_WORD: begin
                be_o    = 4'b1111;
                shifted = wdata_i;
                rdata_o = old_word_i;
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                // Replicating the half places it in both lanes; be_o picks one.
                shifted = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, (addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0])};
            end
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                shifted = {4{wdata_i[7:0]}};
                case (addr_lo_i)
                    2'd0:    rdata_o = {24'h0, old_word_i[7:0]};
                    2'd1:    rdata_o = {24'h0, old_word_i[15:8]};
                    2'd2:    rdata_o = {24'h0, old_word_i[23:16]};
                    default: rdata_o = {24'h0, old_word_i[31:24]};
                endcase
            end
            default: ;
        endcase
    end

    // Merge enabled lanes of the shifted write data into the old word.
    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (be_o[i]) merged_o[8*i +: 8] = shifted[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with sub-word access, error flagging and
// sequential clear after reset.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Address,
    input  logic              Wr,
    input  logic [1:0]        Size,
    input  logic [DATA_W-1:0] Datain,
    output logic [DATA_W-1:0] Dataout,
    output logic              Ready,
    output logic              AddrErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        be;
    logic              req_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idx      = Address[ADDR_W+1:2];
    assign old_word = mem_q[idx];

    mem_lane_merge u_lane_merge (
        .size_i     (Size),
        .addr_lo_i  (Address[1:0]),
        .old_word_i (old_word),
        .wdata_i    (Datain),
        .be_o       (be),
        .merged_o   (merged),
        .rdata_o    (rdata)
    );

    // Illegal size, misalignment or address beyond the array.
    always_comb begin
        req_err = (Size == 2'b11)
                || ((Size == SZ_HALF) && Address[0])
                || ((Size == SZ_WORD) && (Address[1:0] != 2'b00))
                || (Address[31:ADDR_W+2] != '0);
    end

    // Next-state, output and storage-write decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dataout_d  = '0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = '0;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = SERVE;
            end
            SERVE: begin
                if (req_err) begin
                    addr_err_d = 1'b1;
                end else begin
                    dataout_d = rdata;
                    // be is nonzero for every legal size.
                    if (Wr && (be != 4'b0000)) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx;
                        mem_wdata = merged;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Control and output registers, asynchronously reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            dataout_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dataout_q  <= dataout_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage array; contents are established by the clear sequence, not by reset.
    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign Dataout = dataout_q;
    assign AddrErr = addr_err_q;
    assign Ready   = (state_q == SERVE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder.
module tb_data_mem_responder;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic        Wr;
    logic [1:0]  Size;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Ready;
    logic        AddrErr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mb [0:1023];
    logic [32:0] exp_q [$];
    logic [31:0] obs;

    data_mem_responder #(.ADDR_W(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Address (Address),
        .Wr      (Wr),
        .Size    (Size),
        .Datain  (Datain),
        .Dataout (Dataout),
        .Ready   (Ready),
        .AddrErr (AddrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic tb_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b00 && a[1:0] != 2'b00)
            || (a[31:10] != 22'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] s);
        logic [9:0] b;
        b = a[9:0];
        case (s)
            2'b00:   return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
            2'b01:   return {16'h0, mb[b+1], mb[b]};
            default: return {24'h0, mb[b]};
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int n;
        logic [9:0] b;
        b = a[9:0];
        n = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
        for (int k = 0; k < n; k++) mb[b + 10'(k)] = d[8*k +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    endtask

    // One request per cycle: drive on negedge, compare 1 ns after the sampling edge.
    task automatic req(input string tag, input logic [31:0] a, input logic w,
                       input logic [1:0] s, input logic [31:0] d, output logic [31:0] o);
        logic        e;
        logic [32:0] item;
        @(negedge Clk);
        Address = a; Wr = w; Size = s; Datain = d;
        e = tb_err(a, s);
        exp_q.push_back({e, (e ? 32'h0 : model_read(a, s))});
        if (!e && w) model_write(a, s, d);
        @(posedge Clk);
        #1;
        item = exp_q.pop_front();
        check({tag, "_data"}, Dataout, item[31:0]);
        check({tag, "_err"}, {31'h0, AddrErr}, {31'h0, item[32]});
        o = Dataout;
    endtask

    // Count edges after reset release until Ready rises; bounded.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        Wr = 1'b1; Address = 32'h14; Size = 2'b00; Datain = 32'hFFFF_FFFF;
        do begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 10) begin
                check({tag, "_clr_data"}, Dataout, 32'h0);
                check({tag, "_clr_err"}, {31'h0, AddrErr}, 32'h0);
                check({tag, "_clr_ready"}, {31'h0, Ready}, 32'h0);
            end
        end while (!Ready && n < 400);
        check({tag, "_clear_edges"}, 32'(n), 32'd256);
        model_clear();
    endtask

    initial begin
        Reset = 1'b1; Wr = 1'b1; Address = 32'h14; Size = 2'b00; Datain = 32'hFFFF_FFFF;
        #3;
        check("rst_ready", {31'h0, Ready}, 32'h0);
        check("rst_data", Dataout, 32'h0);
        check("rst_err", {31'h0, AddrErr}, 32'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        wait_clear("init");

        req("rd_w5", 32'h14, 1'b0, 2'b00, 32'h0, obs);
        check("rd_w5_const", obs, 32'h0);

        req("wr_dead", 32'h10, 1'b1, 2'b00, 32'hDEAD_BEEF, obs);
        check("wr_dead_old", obs, 32'h0);
        req("rd_dead", 32'h10, 1'b0, 2'b00, 32'h0, obs);
        check("rd_dead_const", obs, 32'hDEAD_BEEF);

        req("wr_1122", 32'h20, 1'b1, 2'b00, 32'h1122_3344, obs);
        req("wr_byte", 32'h21, 1'b1, 2'b10, 32'h0000_00AA, obs);
        req("rd_byte", 32'h20, 1'b0, 2'b00, 32'h0, obs);
        check("rd_byte_const", obs, 32'h1122_AA44);
        req("wr_half", 32'h22, 1'b1, 2'b01, 32'h0000_BEEF, obs);
        req("rd_half_w", 32'h20, 1'b0, 2'b00, 32'h0, obs);
        check("rd_half_w_const", obs, 32'hBEEF_AA44);
        req("rd_half_h", 32'h22, 1'b0, 2'b01, 32'h0, obs);
        check("rd_half_h_const", obs, 32'h0000_BEEF);
        req("rd_b3", 32'h23, 1'b0, 2'b10, 32'h0, obs);
        check("rd_b3_const", obs, 32'h0000_00BE);

        req("err_w13", 32'h13, 1'b1, 2'b00, 32'h5555_5555, obs);
        req("err_h21", 32'h21, 1'b1, 2'b01, 32'h5555_5555, obs);
        req("err_sz3", 32'h20, 1'b1, 2'b11, 32'h5555_5555, obs);
        req("err_oor", 32'h400, 1'b1, 2'b00, 32'h5555_5555, obs);
        req("post_err_10", 32'h10, 1'b0, 2'b00, 32'h0, obs);
        check("post_err_10_const", obs, 32'hDEAD_BEEF);
        req("post_err_20", 32'h20, 1'b0, 2'b00, 32'h0, obs);
        check("post_err_20_const", obs, 32'hBEEF_AA44);
        req("post_err_0", 32'h0, 1'b0, 2'b00, 32'h0, obs);
        check("post_err_0_const", obs, 32'h0);

        req("wr_cafe", 32'h30, 1'b1, 2'b00, 32'hCAFE_F00D, obs);
        req("rd_cafe", 32'h30, 1'b0, 2'b00, 32'h0, obs);
        check("rd_cafe_const", obs, 32'hCAFE_F00D);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'h0, Ready}, 32'h0);
        check("mid_rst_data", Dataout, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        wait_clear("mid");
        req("rd_30_cleared", 32'h30, 1'b0, 2'b00, 32'h0, obs);
        check("rd_30_cleared_const", obs, 32'h0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = (i % 4 < 2) ? 32'h40 : 32'h44;
            if (i % 2 == 0) req("b2b_wr", a, 1'b1, 2'b00, 32'h1000_0000 + 32'(i), obs);
            else            req("b2b_rd", a, 1'b0, 2'b00, 32'h0, obs);
        end
        req("b2b_last_40", 32'h40, 1'b0, 2'b00, 32'h0, obs);
        check("b2b_last_40_const", obs, 32'h1000_0004);
        req("b2b_last_44", 32'h44, 1'b0, 2'b00, 32'h0, obs);
        check("b2b_last_44_const", obs, 32'h1000_0006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
